// File: rtl/sram_access_sequencer.sv
// Single-port SRAM access sequencer: precharge, wordline, write drive and
// sense-amp timing for one request at a time, with registered macro controls.
module sram_access_sequencer #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int PRE_CYCLES   = 1,
    parameter int WL_CYCLES    = 2,
    parameter int SENSE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  precharge_b,
    output logic                  wl_en,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] wdata_out,
    output logic                  write_en,
    output logic                  sense_en,
    input  logic [DATA_WIDTH-1:0] sense_data,
    output logic                  busy
);

    localparam int MAX_PW = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
    localparam int MAX_C  = (MAX_PW > SENSE_CYCLES) ? MAX_PW : SENSE_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C) + 1;

    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WL_LAST    = CNT_W'(WL_CYCLES - 1);
    localparam logic [CNT_W-1:0] SENSE_LAST = CNT_W'(SENSE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACCESS,
        S_SENSE,
        S_CAPTURE,
        S_RECOVER
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             we_q;
    logic             accept;
    logic             pre_b_nx;
    logic             wl_nx;
    logic             we_nx;
    logic             sense_nx;

    assign accept = req_valid & req_ready;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (accept) state_nx = S_PRE;
            S_PRE:     if (cnt == PRE_LAST) state_nx = S_ACCESS;
            S_ACCESS: begin
                if (cnt == WL_LAST) state_nx = we_q ? S_RECOVER : S_SENSE;
            end
            S_SENSE:   if (cnt == SENSE_LAST) state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_IDLE;
            S_RECOVER: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
        // Counter restarts on every state entry and rests at zero in IDLE.
        if (state_nx != state || state == S_IDLE) begin
            cnt_nx = '0;
        end else begin
            cnt_nx = cnt + 1'b1;
        end
    end

    // Macro controls are decoded from the next state so they register cleanly.
    always_comb begin
        pre_b_nx = (state_nx == S_ACCESS) || (state_nx == S_SENSE);
        wl_nx    = pre_b_nx;
        we_nx    = (state_nx == S_ACCESS) && we_q;
        sense_nx = (state_nx != S_SENSE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            addr_out    <= '0;
            wdata_out   <= '0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            precharge_b <= 1'b0;
            wl_en       <= 1'b0;
            write_en    <= 1'b0;
            sense_en    <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            if (accept) begin
                we_q      <= req_we;
                addr_out  <= req_addr;
                wdata_out <= req_wdata;
            end
            req_ready   <= (state_nx == S_IDLE);
            busy        <= (state_nx != S_IDLE);
            precharge_b <= pre_b_nx;
            wl_en       <= wl_nx;
            write_en    <= we_nx;
            sense_en    <= sense_nx;
            rsp_valid   <= (state_nx == S_CAPTURE);
            if (state_nx == S_CAPTURE) begin
                rsp_rdata <= sense_data;
            end
        end
    end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Bench for sram_access_sequencer: vector table, random traffic against a
// phase-schedule reference model, mid-operation reset and a long-timing instance.
module tb_sram_access_sequencer;

    localparam int PRE = 1;
    localparam int WL  = 2;
    localparam int SEN = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [15:0] req_wdata = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        precharge_b;
    logic        wl_en;
    logic [7:0]  addr_out;
    logic [15:0] wdata_out;
    logic        write_en;
    logic        sense_en;
    logic [15:0] sense_data;
    logic        busy;

    logic        req_valid_2 = 1'b0;
    logic        req_ready_2;
    logic        req_we_2 = 1'b0;
    logic [7:0]  req_addr_2 = 8'h00;
    logic [15:0] req_wdata_2 = 16'h0000;
    logic        rsp_valid_2;
    logic [15:0] rsp_rdata_2;
    logic        precharge_b_2;
    logic        wl_en_2;
    logic [7:0]  addr_out_2;
    logic [15:0] wdata_out_2;
    logic        write_en_2;
    logic        sense_en_2;
    logic [15:0] sense_data_2;
    logic        busy_2;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    sram_access_sequencer u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .precharge_b(precharge_b), .wl_en(wl_en),
        .addr_out(addr_out), .wdata_out(wdata_out),
        .write_en(write_en), .sense_en(sense_en),
        .sense_data(sense_data), .busy(busy)
    );

    sram_access_sequencer #(
        .PRE_CYCLES(2), .WL_CYCLES(3), .SENSE_CYCLES(2)
    ) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_2), .req_ready(req_ready_2),
        .req_we(req_we_2), .req_addr(req_addr_2), .req_wdata(req_wdata_2),
        .rsp_valid(rsp_valid_2), .rsp_rdata(rsp_rdata_2),
        .precharge_b(precharge_b_2), .wl_en(wl_en_2),
        .addr_out(addr_out_2), .wdata_out(wdata_out_2),
        .write_en(write_en_2), .sense_en(sense_en_2),
        .sense_data(sense_data_2), .busy(busy_2)
    );

    function automatic logic [15:0] init_word(input logic [7:0] a);
        return (a == 8'h3C) ? 16'hA5A5 : {a, ~a};
    endfunction

    // Physical bitcell array, written only by the DUT's write drivers.
    logic [15:0] arr [256];
    bit          wr_seen [256];

    always @(posedge clk) begin
        if (write_en) begin
            arr[addr_out]     <= wdata_out;
            wr_seen[addr_out] <= 1'b1;
        end
    end

    always_comb begin
        sense_data = 16'h0BAD;
        if (wl_en) begin
            sense_data = wr_seen[addr_out] ? arr[addr_out] : init_word(addr_out);
        end
    end

    always_comb begin
        sense_data_2 = 16'h0BAD;
        if (wl_en_2) sense_data_2 = 16'h5A5A ^ {8'h00, addr_out_2};
    end

    // Reference model: a transaction is a schedule of phases indexed by
    // edges since accept; memory contents update at write accept.
    logic [15:0] ref_mem [256];
    bit          ref_seen [256];
    bit          m_active;
    bit          m_we;
    int          m_k;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;

    function automatic logic [15:0] ref_read(input logic [7:0] a);
        return ref_seen[a] ? ref_mem[a] : init_word(a);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_we     = 1'b0;
            m_k      = 0;
            m_addr   = 8'h00;
            m_wdata  = 16'h0000;
            m_rdata  = 16'h0000;
        end else if (m_active) begin
            m_k = m_k + 1;
            if (!m_we && m_k == PRE + WL + SEN) m_rdata = ref_read(m_addr);
            if (m_k == (m_we ? PRE + WL + 1 : PRE + WL + SEN + 1)) m_active = 1'b0;
        end else if (req_valid) begin
            m_active = 1'b1;
            m_k      = 0;
            m_we     = req_we;
            m_addr   = req_addr;
            m_wdata  = req_wdata;
            if (req_we) begin
                ref_mem[req_addr]  = req_wdata;
                ref_seen[req_addr] = 1'b1;
            end
        end
    end

    typedef struct packed {
        logic        ready;
        logic        pre_b;
        logic        wl;
        logic        we;
        logic        sen;
        logic        rv;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    function automatic exp_t expect_now();
        exp_t e;
        bit   acc;
        bit   sen;
        acc = m_active && m_k >= PRE && m_k < PRE + WL;
        sen = m_active && !m_we && m_k >= PRE + WL && m_k < PRE + WL + SEN;
        e.ready = !m_active;
        e.pre_b = acc | sen;
        e.wl    = acc | sen;
        e.we    = acc & m_we;
        e.sen   = !sen;
        e.rv    = m_active && !m_we && m_k == PRE + WL + SEN;
        e.addr  = m_addr;
        e.wdata = m_wdata;
        e.rdata = m_rdata;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            exp_t e;
            e = expect_now();
            chk("req_ready", 32'(req_ready), 32'(e.ready));
            chk("busy", 32'(busy), 32'(!e.ready));
            chk("precharge_b", 32'(precharge_b), 32'(e.pre_b));
            chk("wl_en", 32'(wl_en), 32'(e.wl));
            chk("write_en", 32'(write_en), 32'(e.we));
            chk("sense_en", 32'(sense_en), 32'(e.sen));
            chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
            chk("addr_out", 32'(addr_out), 32'(e.addr));
            chk("wdata_out", 32'(wdata_out), 32'(e.wdata));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            chk("inv_we_sense", 32'(write_en & ~sense_en), 32'd0);
            chk("inv_wl_pre", 32'(wl_en & ~precharge_b), 32'd0);
            chk("inv2_we_sense", 32'(write_en_2 & ~sense_en_2), 32'd0);
            chk("inv2_wl_pre", 32'(wl_en_2 & ~precharge_b_2), 32'd0);
            chk("busy2", 32'(busy_2), 32'(!req_ready_2));
        end
    end

    task automatic check_reset_vals();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_precharge_b", 32'(precharge_b), 32'd0);
        chk("rst_wl_en", 32'(wl_en), 32'd0);
        chk("rst_addr_out", 32'(addr_out), 32'd0);
        chk("rst_wdata_out", 32'(wdata_out), 32'd0);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_sense_en", 32'(sense_en), 32'd1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && !req_ready; i++) begin
            @(posedge clk);
            #1;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          exp_rsp;
        logic [15:0] exp_rdata;
        int          exp_ready;
        int          exp_wl;
        int          exp_we;
        int          exp_sl;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    function automatic vec_t rd(input logic [7:0] a, input logic [15:0] d);
        vec_t v;
        v = '{1'b0, a, 16'hFFFF, 4, d, 5, 3, 0, 1};
        return v;
    endfunction

    function automatic vec_t wr(input logic [7:0] a, input logic [15:0] d);
        vec_t v;
        v = '{1'b1, a, d, -1, 16'h0000, 4, 2, 2, 0};
        return v;
    endfunction

    initial begin
        int rsp_k;
        int rdy_k;
        int nwl;
        int nwe;
        int nsl;
        int nrv;
        logic [15:0] rdv;

        vecs[0] = rd(8'h3C, 16'hA5A5);
        vecs[1] = wr(8'h10, 16'h1234);
        vecs[2] = wr(8'h55, 16'h1234);
        vecs[3] = rd(8'h55, 16'h1234);
        vecs[4] = rd(8'h10, 16'h1234);
        vecs[5] = rd(8'hFF, 16'hFF00);
        vecs[6] = wr(8'h00, 16'hFFFF);
        vecs[7] = rd(8'h00, 16'hFFFF);
        vecs[8] = rd(8'h01, 16'h01FE);

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Vector table, issued back-to-back with req_valid held high and
        // the next request's fields presented while the current one is busy.
        for (int v = 0; v < NV; v++) begin
            req_valid = 1'b1;
            req_we    = vecs[v].we;
            req_addr  = vecs[v].addr;
            req_wdata = vecs[v].wdata;
            wait_ready();
            @(posedge clk);
            #1;
            if (v + 1 < NV) begin
                req_we    = vecs[v+1].we;
                req_addr  = vecs[v+1].addr;
                req_wdata = vecs[v+1].wdata;
            end else begin
                req_valid = 1'b0;
                req_addr  = 8'hEE;
                req_wdata = 16'hEEEE;
            end
            rsp_k = -1;
            rdy_k = -1;
            nwl = 0;
            nwe = 0;
            nsl = 0;
            rdv = 16'h0000;
            for (int k = 0; k < 40; k++) begin
                if (k > 0 && req_ready) begin
                    rdy_k = k;
                    break;
                end
                if (rsp_valid) begin
                    rsp_k = k;
                    rdv = rsp_rdata;
                end
                nwl += int'(wl_en);
                nwe += int'(write_en);
                nsl += int'(!sense_en);
                if (write_en) begin
                    chk("v_wr_addr", 32'(addr_out), 32'(vecs[v].addr));
                    chk("v_wr_data", 32'(wdata_out), 32'(vecs[v].wdata));
                end
                @(posedge clk);
                #1;
            end
            chk("v_rsp_edge", 32'(rsp_k), 32'(vecs[v].exp_rsp));
            chk("v_ready_edge", 32'(rdy_k), 32'(vecs[v].exp_ready));
            chk("v_wl_cycles", 32'(nwl), 32'(vecs[v].exp_wl));
            chk("v_we_cycles", 32'(nwe), 32'(vecs[v].exp_we));
            chk("v_sense_low", 32'(nsl), 32'(vecs[v].exp_sl));
            if (!vecs[v].we) chk("v_rdata", 32'(rdv), 32'(vecs[v].exp_rdata));
        end

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 8'($urandom_range(0, 15));
            req_wdata = 16'($urandom);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Asynchronous reset while the sense amps are transparent.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h3C;
        wait_ready();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_sense_en", 32'(sense_en), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_reset_vals();
        @(posedge clk);
        #2 rst = 1'b0;
        nrv = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            nrv += int'(rsp_valid);
        end
        chk("post_rst_rsp", 32'(nrv), 32'd0);

        // Long-timing instance: read then write.
        req_valid_2 = 1'b1;
        req_we_2    = 1'b0;
        req_addr_2  = 8'h21;
        chk("p2_ready", 32'(req_ready_2), 32'd1);
        @(posedge clk);
        #1;
        req_valid_2 = 1'b0;
        req_addr_2  = 8'h99;
        rsp_k = -1;
        rdv = 16'h0000;
        for (int k = 0; k < 30; k++) begin
            if (rsp_valid_2) begin
                rsp_k = k;
                rdv = rsp_rdata_2;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("p2_rsp_edge", 32'(rsp_k), 32'd7);
        chk("p2_rdata", 32'(rdv), 32'(16'h5A5A ^ 16'h0021));
        @(posedge clk);
        #1;
        req_valid_2 = 1'b1;
        req_we_2    = 1'b1;
        req_addr_2  = 8'h22;
        req_wdata_2 = 16'hBEEF;
        chk("p2_ready_w", 32'(req_ready_2), 32'd1);
        @(posedge clk);
        #1;
        req_valid_2 = 1'b0;
        rdy_k = -1;
        nwe = 0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0 && req_ready_2) begin
                rdy_k = k;
                break;
            end
            if (write_en_2) begin
                nwe++;
                chk("p2_wdata", 32'(wdata_out_2), 32'h0000BEEF);
                chk("p2_waddr", 32'(addr_out_2), 32'h00000022);
            end
            @(posedge clk);
            #1;
        end
        chk("p2_ready_edge", 32'(rdy_k), 32'd6);
        chk("p2_we_cycles", 32'(nwe), 32'd3);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
